// File: rtl/fifo_last_pipe.sv
// Tail of the drive/free token pipeline: DEPTH valid-bit stages that shift as a unit,
// tail released by an internal hold timer or by an external free, with completion counting.
module fifo_last_pipe #(
    parameter int DEPTH      = 2,
    parameter int FREE_DELAY = 4,
    parameter int EXT_FREE   = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_drive,
    output logic             o_free,
    input  logic             i_free_next,
    output logic [DEPTH-1:0] o_fire,
    output logic             o_done,
    output logic             o_drop,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_fire_cnt
);

    localparam int T = DEPTH - 1;
    localparam logic [7:0] TMAX = 8'(FREE_DELAY - 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] leave;
    logic [DEPTH-1:0] cap;
    logic [7:0]       timer;
    logic             rel;
    logic             accept;

    assign rel    = v[T] & ((EXT_FREE != 0) ? i_free_next : (timer == TMAX));
    assign accept = i_drive & ~v[0];

    // leave[k]: stage k hands its token on this edge; the ready chain is folded in
    // as "next stage empty or itself leaving", evaluated from the tail downwards.
    always_comb begin
        leave    = '0;
        leave[T] = rel;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            leave[DEPTH-1-i] = v[DEPTH-1-i] & (~v[DEPTH-i] | leave[DEPTH-i]);
        end
    end

    assign cap = (leave << 1) | DEPTH'(accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            v          <= '0;
            timer      <= '0;
            o_fire     <= '0;
            o_done     <= 1'b0;
            o_drop     <= 1'b0;
            o_fire_cnt <= '0;
        end else begin
            v      <= cap | (v & ~leave);
            o_fire <= cap;
            o_done <= rel;
            o_drop <= i_drive & v[0];
            if (rel) begin
                o_fire_cnt <= o_fire_cnt + CNT_W'(1);
            end
            if (cap[T]) begin
                timer <= '0;
            end else if (v[T] && EXT_FREE == 0) begin
                timer <= timer + 8'd1;
            end
        end
    end

    assign o_free = ~v[0];
    assign o_busy = |v;

endmodule

// File: tb/tb_fifo_last_pipe.sv
// Directed bench for fifo_last_pipe: timer release, drop, steady throughput,
// external free, mid-flight reset and counter wrap.
module tb_fifo_last_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drv_a = 1'b0, drv_b = 1'b0, drv_c = 1'b0;
    logic       fn_b = 1'b0;
    logic       fn_off = 1'b0;

    logic       free_a, done_a, drop_a, busy_a;
    logic [1:0] fire_a;
    logic [15:0] cnt_a;
    logic       free_b, done_b, drop_b, busy_b;
    logic [1:0] fire_b;
    logic [15:0] cnt_b;
    logic       free_c, done_c, drop_c, busy_c;
    logic [1:0] fire_c;
    logic [3:0] cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_last_pipe #(.DEPTH(2), .FREE_DELAY(4), .EXT_FREE(0), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .i_drive(drv_a), .o_free(free_a), .i_free_next(fn_off),
        .o_fire(fire_a), .o_done(done_a), .o_drop(drop_a), .o_busy(busy_a), .o_fire_cnt(cnt_a)
    );

    fifo_last_pipe #(.DEPTH(2), .FREE_DELAY(4), .EXT_FREE(1), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .i_drive(drv_b), .o_free(free_b), .i_free_next(fn_b),
        .o_fire(fire_b), .o_done(done_b), .o_drop(drop_b), .o_busy(busy_b), .o_fire_cnt(cnt_b)
    );

    fifo_last_pipe #(.DEPTH(2), .FREE_DELAY(4), .EXT_FREE(0), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .i_drive(drv_c), .o_free(free_c), .i_free_next(fn_off),
        .o_fire(fire_c), .o_done(done_c), .o_drop(drop_c), .o_busy(busy_c), .o_fire_cnt(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int dn;
        int last;
        int base;

        step;
        step;
        chk("rst_free_a", 32'(free_a), 1);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_fire_a", 32'(fire_a), 0);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_drop_a", 32'(drop_a), 0);
        chk("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_free_b", 32'(free_b), 1);
        chk("rst_cnt_c", 32'(cnt_c), 0);
        rst = 1'b0;

        // single token, timer release
        for (int c = 0; c < 8; c++) begin
            drv_a = (c == 0);
            chk("t1_fire", 32'(fire_a), (c == 1) ? 1 : (c == 2) ? 2 : 0);
            chk("t1_done", 32'(done_a), (c == 6) ? 1 : 0);
            chk("t1_busy", 32'(busy_a), (c >= 1 && c <= 5) ? 1 : 0);
            chk("t1_free", 32'(free_a), (c == 1) ? 0 : 1);
            chk("t1_cnt", 32'(cnt_a), (c >= 6) ? 1 : 0);
            step;
        end
        drv_a = 1'b0;

        // drive held two cycles: second is dropped
        for (int c = 0; c < 9; c++) begin
            drv_a = (c <= 1);
            chk("t2_drop", 32'(drop_a), (c == 2) ? 1 : 0);
            chk("t2_done", 32'(done_a), (c == 6) ? 1 : 0);
            chk("t2_cnt", 32'(cnt_a), (c >= 6) ? 2 : 1);
            step;
        end
        drv_a = 1'b0;

        // drive whenever free for 40 cycles
        acc = 0;
        dn = 0;
        last = -1;
        base = 2;
        for (int c = 0; c < 40; c++) begin
            chk("t3_drop", 32'(drop_a), 0);
            if (done_a) begin
                dn++;
                if (last >= 0) chk("t3_spacing", c - last, 4);
                last = c;
            end
            chk("t3_cnt", 32'(cnt_a), base + dn);
            chk("t3_occupancy", (acc - dn <= 2) ? 1 : 0, 1);
            drv_a = free_a;
            if (free_a) acc++;
            step;
        end
        drv_a = 1'b0;
        chk("t3_accepts", acc, 11);
        repeat (14) step;
        chk("t3_drain_busy", 32'(busy_a), 0);
        chk("t3_drain_cnt", 32'(cnt_a), 13);

        // external free: fill both stages, third drive dropped
        drv_b = 1'b1;
        chk("t4_c0_free", 32'(free_b), 1);
        step;
        drv_b = 1'b0;
        chk("t4_c1_fire", 32'(fire_b), 1);
        chk("t4_c1_free", 32'(free_b), 0);
        step;
        chk("t4_c2_fire", 32'(fire_b), 2);
        chk("t4_c2_free", 32'(free_b), 1);
        drv_b = 1'b1;
        step;
        chk("t4_c3_fire", 32'(fire_b), 1);
        chk("t4_c3_free", 32'(free_b), 0);
        step;
        drv_b = 1'b0;
        chk("t4_c4_drop", 32'(drop_b), 1);
        chk("t4_c4_free", 32'(free_b), 0);
        step;
        for (int c = 5; c < 7; c++) begin
            chk("t4_hold_free", 32'(free_b), 0);
            chk("t4_hold_done", 32'(done_b), 0);
            chk("t4_hold_drop", 32'(drop_b), 0);
            chk("t4_hold_busy", 32'(busy_b), 1);
            step;
        end
        fn_b = 1'b1;
        chk("t4_c7_done", 32'(done_b), 0);
        step;
        fn_b = 1'b0;
        chk("t4_c8_done", 32'(done_b), 1);
        chk("t4_c8_cnt", 32'(cnt_b), 1);
        chk("t4_c8_free", 32'(free_b), 1);
        chk("t4_c8_fire", 32'(fire_b), 2);
        chk("t4_c8_busy", 32'(busy_b), 1);
        step;
        chk("t4_c9_done", 32'(done_b), 0);
        chk("t4_c9_cnt", 32'(cnt_b), 1);
        fn_b = 1'b1;
        step;
        fn_b = 1'b0;
        chk("t4_c10_done", 32'(done_b), 1);
        chk("t4_c10_cnt", 32'(cnt_b), 2);
        chk("t4_c10_busy", 32'(busy_b), 0);
        step;
        chk("t4_c11_done", 32'(done_b), 0);

        // 4-bit counter wrap over 17 tokens
        acc = 0;
        dn = 0;
        for (int c = 0; c < 300 && dn < 17; c++) begin
            if (done_c) begin
                dn++;
                chk("t6_cnt", 32'(cnt_c), dn % 16);
            end
            drv_c = free_c && (acc < 17);
            if (drv_c) acc++;
            step;
        end
        drv_c = 1'b0;
        chk("t6_tokens", dn, 17);
        chk("t6_final_cnt", 32'(cnt_c), 1);

        // reset with two tokens in flight; drive during reset is ignored
        drv_a = 1'b1;
        step;
        drv_a = 1'b0;
        step;
        drv_a = 1'b1;
        step;
        chk("t5_pre_busy", 32'(busy_a), 1);
        chk("t5_pre_free", 32'(free_a), 0);
        chk("t5_pre_cnt", 32'(cnt_a), 13);
        rst = 1'b1;
        step;
        rst = 1'b0;
        drv_a = 1'b0;
        chk("t5_busy", 32'(busy_a), 0);
        chk("t5_free", 32'(free_a), 1);
        chk("t5_cnt", 32'(cnt_a), 0);
        chk("t5_done", 32'(done_a), 0);
        chk("t5_fire", 32'(fire_a), 0);
        for (int c = 0; c < 8; c++) begin
            step;
            chk("t5_after_done", 32'(done_a), 0);
            chk("t5_after_busy", 32'(busy_a), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_last_pipe.md
# fifo_last_pipe

Clocked, parametrised tail of the drive/free token pipeline used in the FPGA control path. It accepts drive pulses into a DEPTH-stage token pipeline and emits one fire pulse per stage capture. It releases each token from the tail stage either after a programmable hold time (the built-in replacement for the fixed 4-unit free delay) or on an external free. It also counts completed tokens and flags drives that arrive while the pipeline is not free.

## Interface
- DEPTH, 2, number of token stages, 1..16
- FREE_DELAY, 4, cycles a token is held in the tail stage before release when EXT_FREE=0, 1..255
- EXT_FREE, 0, 0 = tail release by internal timer; 1 = tail release by i_free_next
- CNT_W, 16, width of completed-token counter
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- i_drive  in  1  token request, sampled each cycle
- o_free  out  1  stage 0 empty; drive is accepted only when high
- i_free_next  in  1  downstream free (level); used only when EXT_FREE=1
- o_fire  out  DEPTH  o_fire[k] one-cycle pulse when stage k captures a token
- o_done  out  1  one-cycle pulse when a token has left the tail stage
- o_drop  out  1  one-cycle pulse: i_drive seen while o_free low
- o_busy  out  1  any stage holds a token
- o_fire_cnt  out  CNT_W  completed-token count

## Operation
- State: valid bits v[0..DEPTH-1], tail timer (8 bit), counter, registered pulse flags.
- o_free = ~v[0]; o_busy = OR of v. Both derive from registers only and have no input-to-output combinational path.
- Accept: i_drive & o_free sets v[0] at the next edge.
- Drop: i_drive & ~o_free drops the token, leaves state unchanged, and sets o_drop in the next cycle.
- Tail release condition r:
  - EXT_FREE=0: v[D-1] & (timer == FREE_DELAY-1).
  - EXT_FREE=1: v[D-1] & i_free_next.
- Ready chain: rdy[D-1] = ~v[D-1] | r; rdy[k] = ~v[k] | rdy[k+1]. Stage k (k<D-1) moves into k+1 when v[k] & rdy[k+1]. Simultaneous moves in one cycle are allowed, so a full pipeline shifts as a unit on release.
- Timer: cleared when a token enters the tail; increments each cycle the token stays; unused when EXT_FREE=1.
- On release: v[D-1] clears unless refilled in the same edge; the counter increments modulo 2^CNT_W; o_done pulses.
- o_fire[k] is high in the first cycle a new token occupies stage k. Back-to-back captures give consecutive pulses.
- DEPTH=1: stage 0 is also the tail.

## Timing
- Reset (rst high at an edge): v=0, timer=0, o_fire_cnt=0, o_fire=0, o_done=0, o_drop=0. The cycle after that edge shows o_free=1 and o_busy=0.
- i_drive is ignored while rst is high. Reset mid-operation discards all tokens with no o_done and no counter change.
- Empty pipeline, drive in cycle 0: o_fire[k] in cycle 1+k; token in tail from cycle DEPTH.
- EXT_FREE=0: o_done in cycle DEPTH+FREE_DELAY, and o_fire_cnt updates in that same cycle.
- EXT_FREE=1: the token leaves at the edge after the first cycle with i_free_next high while in the tail. o_done follows in the next cycle; minimum tail residency is 1 cycle.
- Max accept rate is 1 per 2 cycles while stage 0 turns over (o_free low the cycle after an accept). Occupancy never exceeds DEPTH.
- Drive and release in the same cycle are independent: the accept lands in stage 0 while the tail releases.
- Counter wraps from 2^CNT_W-1 to 0 without flag.

## Test plan
- Reset, DEPTH=2, FREE_DELAY=4, single drive in cycle 0:
  - o_fire[0] in cycle 1, o_fire[1] in cycle 2.
  - o_done in cycle 6, o_fire_cnt=1 in cycle 6.
  - o_busy low from cycle 6, o_free high from cycle 2.
- Same config, i_drive high cycles 0–1:
  - Cycle 0 accepted.
  - Cycle 1 dropped: o_drop pulse in cycle 2.
  - Exactly one o_done (cycle 6).
- Same config, drive whenever o_free=1 for 40 cycles:
  - Occupancy ≤2, no o_drop.
  - o_done spacing 4 cycles in steady state.
  - o_fire_cnt equals accepted minus in-flight.
- EXT_FREE=1, DEPTH=2, i_free_next low, three drives:
  - Third drive is dropped; tokens held in both stages; o_free=0.
  - Raise i_free_next for 1 cycle: one o_done, then o_free=1 after the shift.
- Assert rst while 2 tokens are in flight:
  - Next cycle: v=0, o_busy=0, o_free=1, o_fire_cnt=0.
  - No o_done pulse.
- CNT_W=4, 17 completed tokens: o_fire_cnt reads 15 after 15 tokens, 0 after 16, 1 after 17.
